// File: rtl/matrix_stream_loader_pkg.sv
// rtl/matrix_stream_loader_pkg.sv - shared sizes, state encoding and packing index for the matrix loader
package matrix_pkg;
    localparam int ELEM_W = 8;
    localparam int N      = 3;
    localparam int BUS_W  = N * N * ELEM_W;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        RUN,
        OUT,
        WAIT_CLR
    } state_t;

    // Row-major element index used for A, B and C packing.
    function automatic int elem_idx(input int i, input int j);
        return i * N + j;
    endfunction
endpackage

// File: rtl/matrix_stream_loader_if.sv
// rtl/matrix_stream_loader_if.sv - valid/ready element stream carrying one matrix element per beat
interface matrix_stream_loader_if #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - streams A/B into matrix_mult and C back out as an element stream
// Optional RUN watchdog enabled by defining MATRIX_TIMEOUT_EN.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int ELEM_W      = matrix_pkg::ELEM_W,
    parameter int N           = matrix_pkg::N,
    parameter int TIMEOUT_CYC = 1024,
    localparam int BUS_W      = N * N * ELEM_W
) (
    input  logic                   Clock,
    input  logic                   reset,
    matrix_stream_loader_if.slave  in_s,
    matrix_stream_loader_if.master out_m,
    output logic [BUS_W-1:0]       mm_A,
    output logic [BUS_W-1:0]       mm_B,
    output logic                   mm_Enable,
    input  logic [BUS_W-1:0]       mm_C,
    input  logic                   mm_done,
    output logic                   busy,
    output logic                   err
);
    localparam int              CNT_W = $clog2(N * N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N * N - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_W-1:0]   a_q, a_d;
    logic [BUS_W-1:0]   b_q, b_d;
    logic [BUS_W-1:0]   c_q, c_d;
    logic               en_q, en_d;
    logic               in_load;

    assign in_load   = (state_q == LOAD_A) || (state_q == LOAD_B);
    // Gated by reset so no element is taken in the reset cycle itself.
    assign in_s.ready = in_load && !reset;

    assign mm_A      = a_q;
    assign mm_B      = b_q;
    assign mm_Enable = en_q;
    assign busy      = !((state_q == LOAD_A) && (cnt_q == '0));

    assign out_m.valid = (state_q == OUT);
    assign out_m.data  = c_q[cnt_q * ELEM_W +: ELEM_W];
    assign out_m.last  = (state_q == OUT) && (cnt_q == LAST);

`ifdef MATRIX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            wd_expired;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign wd_d       = (state_q == RUN) ? wd_q + 1'b1 : '0;
    assign err        = err_q;

    always_ff @(posedge Clock) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    // Constant 0: the watchdog is not built in this configuration.
    assign err = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        en_d    = en_q;
`ifdef MATRIX_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            LOAD_A, LOAD_B: begin
                if (in_s.valid) begin
                    if (state_q == LOAD_A) a_d[cnt_q * ELEM_W +: ELEM_W] = in_s.data;
                    else                   b_d[cnt_q * ELEM_W +: ELEM_W] = in_s.data;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (state_q == LOAD_A) begin
                            state_d = LOAD_B;
                        end else begin
                            state_d = RUN;
                            en_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (mm_done) begin
                    c_d     = mm_C;
                    en_d    = 1'b0;
                    state_d = OUT;
`ifdef MATRIX_TIMEOUT_EN
                end else if (wd_expired) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = WAIT_CLR;
`endif
                end
            end
            OUT: begin
                if (out_m.ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        // A level done still high would otherwise be mistaken for the next result.
                        state_d = mm_done ? WAIT_CLR : LOAD_A;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_CLR: begin
                if (!mm_done) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            en_q    <= en_d;
        end
    end
endmodule
